adder_stim_checker: RTL and testbench
=====================================

ADDER_STIM_CHECKER -- requirements
Module: adder_stim_checker

Interface
REQ-001 Parameter SEED_A, default 32'hACE1_2468, initial state of the operand-A LFSR; zero is replaced by 32'h1.
REQ-002 Parameter SEED_B, default 32'h1357_BDF0, initial state of the operand-B LFSR; zero is replaced by 32'h1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 num_vectors  input  16  vectors per run; sampled on the start edge.
REQ-007 settle_cycles  input  4  wait cycles between driving and checking a vector; sampled on the start edge.
REQ-008 dut_a, dut_b  output  32 each  operands to the adder under test.
REQ-009 dut_ci  output  1  carry-in to the adder under test.
REQ-010 dut_s  input  32  sum from the adder under test.
REQ-011 dut_co  input  1  carry-out from the adder under test.
REQ-012 busy  output  1  high from LOAD through CHECK of the last vector.
REQ-013 done  output  1  single-cycle end-of-run pulse.
REQ-014 pass  output  1  high when the last run had zero mismatches; held until the next start.
REQ-015 err_count  output  16  mismatches in the current/last run, saturating at 16'hFFFF.
REQ-016 first_fail_idx  output  16  index of the first mismatching vector; 16'hFFFF = none.

Function
REQ-017 FSM states IDLE, LOAD, SETTLE, CHECK, DONE; one state per cycle except SETTLE.
REQ-018 IDLE: start with num_vectors>0 -> LOAD; start with num_vectors=0 -> DONE; start outside IDLE is ignored.
REQ-019 On the start edge: clear err_count, set first_fail_idx=16'hFFFF, clear pass, set vector index=0.
REQ-020 LOAD: dut_a/dut_b take the current LFSR states; dut_ci = a[0]^b[0]; expected {co,s} = a+b+ci computed internally at 33 bits; wait counter = settle_cycles.
REQ-021 LOAD -> SETTLE if settle_cycles>0, else -> CHECK; SETTLE decrements and -> CHECK on the cycle the counter reaches 1.
REQ-022 CHECK: compare {dut_co,dut_s} to expected; on mismatch increment err_count (saturating) and, if first_fail_idx=16'hFFFF, load the current index.
REQ-023 CHECK: advance both LFSRs one step, increment index; index equals num_vectors -> DONE, else -> LOAD.
REQ-024 LFSRs: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (tap mask 32'h8020_0003), shift right.
REQ-025 DONE: done=1 for exactly one cycle; pass = (err_count==0); -> IDLE.
REQ-026 dut_a, dut_b, dut_ci hold their value outside LOAD; they change only in LOAD.
REQ-027 Latency: done is high N*(S+2)+1 cycles after the start edge (N=num_vectors, S=settle_cycles); N=0 gives 1 cycle.
REQ-028 LFSRs are not reseeded between runs; consecutive runs continue the sequence.

Reset
REQ-029 rst asserted at any time, including mid-run, forces IDLE; busy=0, done=0, pass=0, err_count=0, first_fail_idx=16'hFFFF, dut_a=0, dut_b=0, dut_ci=0, LFSRs to SEED_A/SEED_B.
REQ-030 After rst deasserts, the first start begins the run from the seed vectors.

Structure
REQ-031 A shared package holds the FSM state enumeration, the LFSR tap mask, and the 16'hFFFF "no failure" constant.
REQ-032 One sub-module lfsr32 (parameterised seed, step enable, state output) is instantiated twice.

Verification
REQ-033 Ideal behavioural adder attached, N=100, S=2, start -> done 401 cycles later, pass=1, err_count=0, first_fail_idx=16'hFFFF.
REQ-034 Adder with dut_s[5] stuck at 0, N=50, S=1 -> pass=0, err_count = model count of vectors with expected s[5]=1, first_fail_idx = first such index.
REQ-035 N=0 with start -> done on the next cycle, pass=1, err_count=0, busy never high.
REQ-036 rst pulsed during SETTLE of vector 10 -> all outputs at reset values; a new run of N=5 reproduces the seed vectors exactly.
REQ-037 start reasserted while busy -> ignored; run length and results unchanged.
REQ-038 Adder inverting dut_co, N=3, S=0 -> err_count=3, first_fail_idx=0, done 7 cycles after start.

Source files
------------

// File: rtl/adder_stim_checker_pkg.sv
// Shared definitions for the adder stimulus checker.
// Holds the sequencer state enumeration, the LFSR feedback mask, the
// "no failure recorded" marker and the LFSR helper functions.
package adder_stim_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1, shifting right.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // first_fail_idx marker: no failing vector recorded for the current run.
  localparam logic [15:0] NO_FAIL = 16'hFFFF;

  // One right-shift step of the Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    logic [31:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  function automatic logic [31:0] lfsr_fix_seed(input logic [31:0] seed);
    return (seed == 32'h0) ? 32'h0000_0001 : seed;
  endfunction

endpackage

// File: rtl/adder_stim_checker_if.sv
// Bus between the stimulus checker and the adder under test.
//   dut_a, dut_b, dut_ci : operands driven by the checker (master)
//   dut_s, dut_co        : sum and carry returned by the adder (slave)
interface adder_stim_checker_if;
  logic [31:0] dut_a;
  logic [31:0] dut_b;
  logic        dut_ci;
  logic [31:0] dut_s;
  logic        dut_co;

  modport master (output dut_a, output dut_b, output dut_ci,
                  input  dut_s, input  dut_co);
  modport slave  (input  dut_a, input  dut_b, input  dut_ci,
                  output dut_s, output dut_co);
endinterface

// File: rtl/adder_stim_checker_lfsr32.sv
// 32-bit Galois LFSR with a parameterised seed.
//   clk, rst : clock and asynchronous active-high reset (reloads SEED)
//   en       : advance one step on this rising edge
//   state    : current LFSR contents
module lfsr32
  import adder_stim_checker_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // Next-state: step only when enabled.
  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = lfsr_step(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // State register; reset returns to the (zero-safe) seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= lfsr_fix_seed(SEED);
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/adder_stim_checker.sv
// Self-contained stimulus generator and checker for a 32-bit adder.
// Drives pseudo-random operands from two LFSRs, waits a programmable
// number of settle cycles, compares the adder result against an internal
// 33-bit reference and reports mismatch count and first failing index.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : one-cycle run request (honoured only when idle)
//   num_vectors    : vectors per run, latched on start
//   settle_cycles  : wait cycles between drive and check, latched on start
//   bus            : operand/result bus to the adder under test
//   busy, done     : run in progress / one-cycle end-of-run pulse
//   pass           : last run had no mismatches
//   err_count      : saturating mismatch count
//   first_fail_idx : first mismatching vector, 16'hFFFF if none
module adder_stim_checker
  import adder_stim_checker_pkg::*;
#(
  parameter logic [31:0] SEED_A = 32'hACE1_2468,
  parameter logic [31:0] SEED_B = 32'h1357_BDF0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 num_vectors,
  input  logic [3:0]                  settle_cycles,
  adder_stim_checker_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [15:0]                 err_count,
  output logic [15:0]                 first_fail_idx
);

  state_e      state_q, state_d;
  logic [15:0] n_q, n_d, idx_q, idx_d;
  logic [3:0]  settle_q, settle_d, wait_q, wait_d;
  logic [32:0] exp_q, exp_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        ci_q, ci_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0] err_q, err_d, ff_q, ff_d;
  logic        lfsr_en;
  logic [31:0] lfsr_a, lfsr_b;

  lfsr32 #(.SEED(SEED_A)) u_lfsr_a (.clk(clk), .rst(rst), .en(lfsr_en), .state(lfsr_a));
  lfsr32 #(.SEED(SEED_B)) u_lfsr_b (.clk(clk), .rst(rst), .en(lfsr_en), .state(lfsr_b));

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    wait_d   = wait_q;
    exp_d    = exp_q;
    a_d      = a_q;
    b_d      = b_q;
    ci_d     = ci_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ff_d     = ff_q;
    lfsr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d      = num_vectors;
          settle_d = settle_cycles;
          idx_d    = 16'd0;
          err_d    = 16'd0;
          ff_d     = NO_FAIL;
          pass_d   = 1'b0;
          state_d  = (num_vectors != 16'd0) ? ST_LOAD : ST_DONE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        a_d     = lfsr_a;
        b_d     = lfsr_b;
        ci_d    = lfsr_a[0] ^ lfsr_b[0];
        exp_d   = {1'b0, lfsr_a} + {1'b0, lfsr_b} + {32'd0, lfsr_a[0] ^ lfsr_b[0]};
        wait_d  = settle_q;
        state_d = (settle_q != 4'd0) ? ST_SETTLE : ST_CHECK;
      end
      ST_SETTLE: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_CHECK: begin
        lfsr_en = 1'b1;
        idx_d   = idx_q + 16'd1;
        if ({bus.dut_co, bus.dut_s} != exp_q) begin
          err_d = (err_q != 16'hFFFF) ? (err_q + 16'd1) : err_q;
          ff_d  = (ff_q == NO_FAIL) ? idx_q : ff_q;
        end else begin
          err_d = err_q;
        end
        state_d = ((idx_q + 16'd1) == n_q) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        pass_d  = (err_q == 16'd0);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // done is a registered pulse one cycle after the DONE state.
    done_d = (state_q == ST_DONE);
    busy_d = (state_d == ST_LOAD) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      n_q      <= 16'd0;
      idx_q    <= 16'd0;
      settle_q <= 4'd0;
      wait_q   <= 4'd0;
      exp_q    <= 33'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      ci_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 16'd0;
      ff_q     <= NO_FAIL;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      wait_q   <= wait_d;
      exp_q    <= exp_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ci_q     <= ci_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
    end
  end

  assign bus.dut_a      = a_q;
  assign bus.dut_b      = b_q;
  assign bus.dut_ci     = ci_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ff_q;

endmodule

// File: tb/tb_adder_stim_checker.sv
// Bench for adder_stim_checker: behavioural adder with selectable faults
// and a vector-level reference model of the checker's expected results.
module tb_adder_stim_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vectors;
  logic [3:0]  settle_cycles;
  logic        busy, done, pass;
  logic [15:0] err_count, first_fail_idx;

  int n_checks = 0;
  int n_passed = 0;

  // 0 = ideal adder, 1 = sum bit 5 stuck at 0, 2 = carry-out inverted
  int mode = 0;

  always #5 clk = ~clk;

  adder_stim_checker_if bus ();

  adder_stim_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .settle_cycles(settle_cycles), .bus(bus), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  logic [32:0] sum_v;
  logic [31:0] s_v;
  logic        co_v;

  // Behavioural adder under test with optional planted faults.
  always_comb begin
    sum_v = {1'b0, bus.dut_a} + {1'b0, bus.dut_b} + {32'd0, bus.dut_ci};
    s_v   = sum_v[31:0];
    co_v  = sum_v[32];
    if (mode == 1) s_v[5] = 1'b0;
    else if (mode == 2) co_v = ~sum_v[32];
  end
  assign bus.dut_s  = s_v;
  assign bus.dut_co = co_v;

  // Reference model state
  logic [31:0] ma, mb, last_a, last_b;
  logic        last_ci;

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic model_reset();
    ma = 32'hACE1_2468; mb = 32'h1357_BDF0;
    last_a = 32'd0; last_b = 32'd0; last_ci = 1'b0;
  endtask

  task automatic model_run(input int n, input int m, output int errs, output int ffi);
    logic [32:0] e;
    logic        bad;
    errs = 0; ffi = 65535;
    for (int i = 0; i < n; i++) begin
      last_a = ma; last_b = mb; last_ci = ma[0] ^ mb[0];
      e = {1'b0, ma} + {1'b0, mb} + {32'd0, last_ci};
      bad = (m == 1) ? e[5] : (m == 2);
      if (bad) begin
        errs++;
        if (ffi == 65535) ffi = i;
      end
      ma = step(ma); mb = step(mb);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_pass"}, pass, 0);
    chk({pfx, "_err"}, err_count, 0);
    chk({pfx, "_ffi"}, first_fail_idx, 16'hFFFF);
    chk({pfx, "_a"}, bus.dut_a, 0);
    chk({pfx, "_b"}, bus.dut_b, 0);
    chk({pfx, "_ci"}, bus.dut_ci, 0);
  endtask

  task automatic run(input string tag, input int n, input int s, input int m, input bit poke);
    int errs, ffi, cycles;
    bit busy_seen, done_seen;
    mode = m;
    model_run(n, m, errs, ffi);
    @(negedge clk);
    start = 1'b1; num_vectors = 16'(n); settle_cycles = 4'(s);
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0; busy_seen = busy; done_seen = 1'b0;
    while (!done_seen && cycles < 5000) begin
      if (poke && cycles == 4) begin
        start = 1'b1; num_vectors = 16'(n + 7); settle_cycles = 4'(s ^ 1);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
      if (busy) busy_seen = 1'b1;
      done_seen = done;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cycles, n * (s + 2) + 1);
    chk({tag, "_pass"}, pass, (errs == 0));
    chk({tag, "_err"}, err_count, errs);
    chk({tag, "_ffi"}, first_fail_idx, ffi);
    chk({tag, "_a"}, bus.dut_a, last_a);
    chk({tag, "_b"}, bus.dut_b, last_b);
    chk({tag, "_ci"}, bus.dut_ci, last_ci);
    chk({tag, "_busy_seen"}, busy_seen, (n != 0));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_vectors = 16'd0; settle_cycles = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;

    run("ideal_n100_s2", 100, 2, 0, 1'b0);
    run("s5_stuck_n50_s1", 50, 1, 1, 1'b0);
    run("co_inv_n3_s0", 3, 0, 2, 1'b0);
    run("n0", 0, 3, 0, 1'b0);
    run("start_while_busy", 10, 1, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      run("random", $urandom_range(1, 30), $urandom_range(0, 15), $urandom_range(0, 2), 1'b0);
    end

    // Reset during SETTLE of vector 10 (N=20, S=3).
    mode = 0;
    @(negedge clk);
    start = 1'b1; num_vectors = 16'd20; settle_cycles = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (51) @(posedge clk);
    #1;
    chk("midrun_busy", busy, 1);
    rst = 1'b1;
    #2;
    check_reset_outputs("midrun_reset");
    @(negedge clk); rst = 1'b0;
    model_reset();
    run("after_reset_n5", 5, 2, 0, 1'b0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
